apb_master: RTL and testbench

APB4 initiator that drives the timer's APB slave port (`tim_*` signals) from a simple valid/ready command interface. It converts one command into one APB transfer (SETUP then ACCESS), honours wait states, captures read data and slave error, and aborts hung transfers with a wait-state timeout. It is used as the bus-side driver in the timer subsystem testbench/SoC glue and as the reference initiator for timer register access.

---
 rtl/apb_master.sv | 149 ++++++++++++++
 tb/tb_apb_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB4 initiator: one valid/ready command becomes one SETUP+ACCESS transfer with wait-state timeout
module apb_master #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  tim_psel,
    output logic                  tim_penable,
    output logic                  tim_pwrite,
    output logic [ADDR_W-1:0]     tim_paddr,
    output logic [DATA_W-1:0]     tim_pwdata,
    output logic [DATA_W/8-1:0]   tim_pstrb,
    input  logic [DATA_W-1:0]     tim_prdata,
    input  logic                  tim_pready,
    input  logic                  tim_pslverr
);
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t              state_q;
    logic                ready_q;
    logic                busy_q;
    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                rsp_timeout_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic [CNT_W-1:0]    wait_cnt_d;
    logic                timeout_hit;

    always_comb begin
        wait_cnt_d  = wait_cnt_q + CNT_W'(1);
        // TIMEOUT of zero means wait forever, so the threshold never fires.
        timeout_hit = (TIMEOUT > 0) && (wait_cnt_q == CNT_LAST);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_valid && ready_q) begin
                        state_q  <= SETUP;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        psel_q   <= 1'b1;
                        pwrite_q <= cmd_write;
                        paddr_q  <= cmd_addr;
                        pwdata_q <= cmd_wdata;
                        pstrb_q  <= cmd_write ? cmd_strb : '0;
                    end
                end
                SETUP: begin
                    state_q    <= ACCESS;
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                end
                ACCESS: begin
                    if (tim_pready) begin
                        state_q       <= IDLE;
                        ready_q       <= 1'b1;
                        busy_q        <= 1'b0;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= pwrite_q ? '0 : tim_prdata;
                        rsp_err_q     <= tim_pslverr;
                        rsp_timeout_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q       <= IDLE;
                        ready_q       <= 1'b1;
                        busy_q        <= 1'b0;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ready_q   <= 1'b1;
                    busy_q    <= 1'b0;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = ready_q;
    assign busy        = busy_q;
    assign tim_psel    = psel_q;
    assign tim_penable = penable_q;
    assign tim_pwrite  = pwrite_q;
    assign tim_paddr   = paddr_q;
    assign tim_pwdata  = pwdata_q;
    assign tim_pstrb   = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - vector table plus response scoreboard for apb_master with a behavioural APB slave
module tb_apb_master;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic        tim_psel;
    logic        tim_penable;
    logic        tim_pwrite;
    logic [11:0] tim_paddr;
    logic [31:0] tim_pwdata;
    logic [3:0]  tim_pstrb;
    logic [31:0] tim_prdata = '0;
    logic        tim_pready = 1'b0;
    logic        tim_pslverr = 1'b0;

    apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
        .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
        .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr)
    );

    always #5 sys_clk = ~sys_clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        bit          slverr;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_to;
        int          exp_lat;
        logic [3:0]  exp_pstrb;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          to;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    function automatic vec_t mk(input bit w, input logic [11:0] a, input logic [31:0] wd,
                                input logic [3:0] s, input int wt, input bit se,
                                input logic [31:0] pr, input logic [31:0] er, input bit ee,
                                input bit et, input int lat, input logic [3:0] ps);
        vec_t v;
        v.write = w; v.addr = a; v.wdata = wd; v.strb = s; v.waits = wt; v.slverr = se;
        v.prdata = pr; v.exp_rdata = er; v.exp_err = ee; v.exp_to = et; v.exp_lat = lat;
        v.exp_pstrb = ps;
        return v;
    endfunction

    // Slave knobs; waits < 0 means the slave never raises pready.
    int          slv_waits = 0;
    bit          slv_err = 1'b0;
    logic [31:0] slv_rdata = '0;
    bit          slv_addr_data = 1'b0;
    bit          slv_idle_ready = 1'b0;
    bit          slv_idle_err = 1'b0;
    int          slv_cnt = 0;
    logic [11:0] setup_addr = '0;
    logic [31:0] setup_wdata = '0;
    logic [3:0]  setup_strb = '0;
    logic        setup_write = 1'b0;

    always @(negedge sys_clk) begin
        if (tim_psel && tim_penable) begin
            chk("paddr_stable", tim_paddr, setup_addr);
            chk("pwdata_stable", tim_pwdata, setup_wdata);
            chk("pstrb_stable", tim_pstrb, setup_strb);
            chk("pwrite_stable", tim_pwrite, setup_write);
            if (slv_waits >= 0 && slv_cnt == slv_waits) begin
                tim_pready  = 1'b1;
                tim_pslverr = slv_err;
                tim_prdata  = slv_addr_data ? {20'hCAFE0, tim_paddr} : slv_rdata;
            end else begin
                tim_pready  = 1'b0;
                tim_pslverr = slv_idle_err;
                tim_prdata  = 32'h0BAD_0BAD;
            end
            slv_cnt++;
        end else begin
            if (tim_psel) begin
                setup_addr  = tim_paddr;
                setup_wdata = tim_pwdata;
                setup_strb  = tim_pstrb;
                setup_write = tim_pwrite;
            end
            slv_cnt     = 0;
            tim_pready  = slv_idle_ready;
            tim_pslverr = slv_idle_err;
            tim_prdata  = 32'hBAD0_BAD0;
        end
    end

    always @(negedge sys_clk) begin
        if (!sys_rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_timeout", rsp_timeout, e.to);
                chk("rsp_latency", cyc - e.acc, e.lat);
                chk("rsp_psel_low", {tim_psel, tim_penable}, 2'b00);
                chk("rsp_cmd_ready", cmd_ready, 1'b1);
            end
        end
    end

    // Called on a negedge; returns on the negedge of the SETUP cycle.
    task automatic send(input vec_t v, input bit hold, input bit track, output int acc_cyc);
        int n;
        bit r, ok;
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb;
        slv_waits = v.waits; slv_err = v.slverr; slv_rdata = v.prdata;
        ok = 1'b0; n = 0;
        while (!ok && n < 200) begin
            r = cmd_ready;
            @(posedge sys_clk);
            ok = r;
            n++;
            @(negedge sys_clk);
        end
        acc_cyc = -1;
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
        end else begin
            exp_t e;
            acc_cyc = cyc;
            e.rdata = v.exp_rdata; e.err = v.exp_err; e.to = v.exp_to;
            e.lat = v.exp_lat; e.acc = acc_cyc;
            if (track) exp_q.push_back(e);
            chk("setup_psel_pen", {tim_psel, tim_penable}, 2'b10);
            chk("setup_paddr", tim_paddr, v.addr);
            chk("setup_pwrite", tim_pwrite, v.write);
            chk("setup_pstrb", tim_pstrb, v.exp_pstrb);
            chk("setup_busy_ready", {busy, cmd_ready}, 2'b10);
            if (v.write) chk("setup_pwdata", tim_pwdata, v.wdata);
            if (!hold) cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        chk("rsp_outstanding", exp_q.size(), 0);
        @(negedge sys_clk);
    endtask

    vec_t vecs[8];
    vec_t b2b[4];
    int   acc[4];
    int   dummy;

    initial begin
        vecs[0] = mk(1, 12'h004, 32'h0000_0103, 4'hF,  0, 0, 32'h0,         32'h0,         0, 0,  2, 4'hF);
        vecs[1] = mk(0, 12'h008, 32'h1111_1111, 4'hF,  3, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0,  5, 4'h0);
        vecs[2] = mk(1, 12'hFFC, 32'h1234_5678, 4'hF,  0, 1, 32'h0,         32'h0,         1, 0,  2, 4'hF);
        vecs[3] = mk(0, 12'h010, 32'h0,         4'h0, -1, 0, 32'h5555_5555, 32'h0,         1, 1, 17, 4'h0);
        vecs[4] = mk(0, 12'h014, 32'h0,         4'h0, 15, 0, 32'h1357_9BDF, 32'h1357_9BDF, 0, 0, 17, 4'h0);
        vecs[5] = mk(1, 12'h020, 32'hAABB_CCDD, 4'h0,  1, 0, 32'h7777_7777, 32'h0,         0, 0,  3, 4'h0);
        vecs[6] = mk(0, 12'h024, 32'h0,         4'hF,  2, 1, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1, 0,  4, 4'h0);
        vecs[7] = mk(1, 12'h028, 32'hFEED_F00D, 4'h5, -1, 0, 32'h9999_9999, 32'h0,         1, 1, 17, 4'h5);

        repeat (3) @(negedge sys_clk);
        chk("reset_outputs",
            {cmd_ready, busy, tim_psel, tim_penable, tim_pwrite, rsp_valid, rsp_err, rsp_timeout},
            8'h00);
        chk("reset_bus", {tim_paddr, tim_pwdata, tim_pstrb, rsp_rdata}, 80'h0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("ready_after_reset", cmd_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            send(vecs[i], 1'b0, 1'b1, dummy);
            wait_done();
        end

        // pready and pslverr outside the pready cycle of ACCESS must be ignored.
        slv_idle_ready = 1'b1;
        slv_idle_err   = 1'b1;
        send(mk(0, 12'h030, 32'h0, 4'hF, 2, 0, 32'h1122_3344, 32'h1122_3344, 0, 0, 4, 4'h0),
             1'b0, 1'b1, dummy);
        wait_done();
        slv_idle_ready = 1'b0;
        slv_idle_err   = 1'b0;

        // Back-to-back with cmd_valid held; slave returns address-derived read data.
        slv_addr_data = 1'b1;
        b2b[0] = mk(1, 12'h040, 32'hA000_0001, 4'hF, 0, 0, 32'h0, 32'h0,         0, 0, 2, 4'hF);
        b2b[1] = mk(0, 12'h044, 32'h0,         4'hF, 0, 0, 32'h0, 32'hCAFE_0044, 0, 0, 2, 4'h0);
        b2b[2] = mk(1, 12'h048, 32'hA000_0003, 4'h3, 0, 0, 32'h0, 32'h0,         0, 0, 2, 4'h3);
        b2b[3] = mk(0, 12'h04C, 32'h0,         4'hF, 0, 0, 32'h0, 32'hCAFE_004C, 0, 0, 2, 4'h0);
        for (int i = 0; i < 4; i++) send(b2b[i], (i < 3), 1'b1, acc[i]);
        for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], 3);
        wait_done();
        slv_addr_data = 1'b0;

        // Reset during a hung ACCESS kills the transfer without a response.
        send(mk(0, 12'h0A0, 32'h0, 4'h0, -1, 0, 32'h0, 32'h0, 0, 0, 0, 4'h0), 1'b0, 1'b0, dummy);
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("pre_reset_access", {tim_psel, tim_penable}, 2'b11);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("midreset_bus", {tim_psel, tim_penable, busy, rsp_valid, cmd_ready}, 5'b00000);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("ready_after_midreset", cmd_ready, 1'b1);
        repeat (3) @(negedge sys_clk);
        send(mk(0, 12'h050, 32'h0, 4'hF, 1, 0, 32'h600D_F00D, 32'h600D_F00D, 0, 0, 3, 4'h0),
             1'b0, 1'b1, dummy);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
